store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered stores (power of two, min 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 st_valid  input  1  store presented this cycle (from address/byte-lane stage).
REQ-005 st_addr  input  12  word address of store.
REQ-006 st_we  input  4  byte write enables, already lane-aligned.
REQ-007 st_data  input  32  lane-aligned store data.
REQ-008 ld_valid  input  1  load presented this cycle.
REQ-009 ld_addr  input  12  word address of load.
REQ-010 mem_ready  input  1  data memory accepts the presented write this cycle.
REQ-011 mem_we  output  4  byte write enables to data memory.
REQ-012 mem_addr  output  12  word address to data memory.
REQ-013 mem_din  output  32  write data to data memory.
REQ-014 stall  output  1  pipeline must hold the current instruction.
REQ-015 empty  output  1  no pending stores.
REQ-016 count  output  $clog2(DEPTH)+1  number of pending stores.

Function
REQ-017 The block shall hold pending stores in a circular FIFO of DEPTH entries {addr, we, data} with read pointer, write pointer and occupancy count.
REQ-018 A push shall occur on a clock edge when st_valid=1, st_we!=0, and count<DEPTH; st_valid with st_we=0 shall be ignored (no push, no stall).
REQ-019 When count=DEPTH and st_valid=1 with st_we!=0, stall shall be 1 and no push shall occur, even if a pop occurs in the same cycle (full is judged on registered count only).
REQ-020 When count>0, mem_we/mem_addr/mem_din shall equal the head entry combinationally; when count=0 they shall be 0.
REQ-021 A pop shall occur on a clock edge when count>0 and mem_ready=1; mem_ready while empty shall have no effect.
REQ-022 Simultaneous push and pop with 0<count<DEPTH shall leave count unchanged and advance both pointers.
REQ-023 Push into an empty buffer shall not appear on mem_* until the following cycle (one-cycle minimum store latency).
REQ-024 Pointers shall wrap modulo DEPTH; entries shall drain strictly in push order.
REQ-025 Load hazard: when ld_valid=1 and any pending entry has addr==ld_addr, stall shall be 1; it shall deassert in the cycle after the last matching entry pops.
REQ-026 Loads to addresses not pending shall never stall; loads never modify buffer state.
REQ-027 stall shall be the OR of REQ-019 and REQ-025 conditions, purely combinational from registered state and current inputs, with no dependence on mem_ready.
REQ-028 empty shall equal (count==0); count shall never exceed DEPTH nor underflow.
REQ-029 Duplicate addresses shall be stored as separate entries (no merging).

Reset
REQ-030 rst_n=0 shall immediately clear count and both pointers, discarding pending stores; mem_we=0, mem_addr=0, mem_din=0, stall=0, empty=1, count=0 while in reset.
REQ-031 Reset asserted mid-drain shall abort the drain; no partial or repeated write after rst_n returns high.
REQ-032 Entry storage contents need not be reset.

Verification
REQ-033 Single store: push {addr=0x010, we=4'b1111, data=0xDEADBEEF}, mem_ready=1 -> next cycle mem_we=4'hF, mem_addr=0x010, mem_din=0xDEADBEEF; following cycle empty=1.
REQ-034 Fill: mem_ready=0, push 4 stores to 0x001..0x004, then 5th store -> count=4, stall=1, 5th not accepted; raise mem_ready -> drains 0x001,0x002,0x003,0x004 in order.
REQ-035 Full plus pop: count=4, st_valid=1 and mem_ready=1 same cycle -> stall=1, count becomes 3, store retried next cycle and accepted (count stays 3 with pop).
REQ-036 Load hazard: pending SB {0x020, 4'b0010}, ld_valid ld_addr=0x020, mem_ready=0 -> stall=1; ld_addr=0x021 -> stall=0; mem_ready=1 -> stall=0 in cycle after pop.
REQ-037 Wrap: push/pop 10 stores, concurrent and interleaved -> all 10 appear on mem_* in order, count returns to 0.
REQ-038 Reset mid-operation: count=3, drop rst_n for 1 cycle asynchronously -> mem_we=0, count=0, empty=1 immediately; no stale write afterward.

Source files
------------

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store buffer pipeline/memory signal bundle
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     st_valid;
    logic [11:0]              st_addr;
    logic [3:0]               st_we;
    logic [31:0]              st_data;
    logic                     ld_valid;
    logic [11:0]              ld_addr;
    logic                     mem_ready;
    logic [3:0]               mem_we;
    logic [11:0]              mem_addr;
    logic [31:0]              mem_din;
    logic                     stall;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output st_valid, st_addr, st_we, st_data, ld_valid, ld_addr, mem_ready,
        input  mem_we, mem_addr, mem_din, stall, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_we, st_data, ld_valid, ld_addr, mem_ready,
        output mem_we, mem_addr, mem_din, stall, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer draining to data memory with load-hazard stall
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [11:0]   addr_q [DEPTH];
    logic [3:0]    we_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic full;
    logic has_entry;
    logic st_req;
    logic push;
    logic pop;
    logic ld_hit;

    always_comb begin
        full      = (cnt == CW'(DEPTH));
        has_entry = (cnt != '0);
        st_req    = sb.st_valid && (sb.st_we != 4'b0000);
        push      = st_req && !full;
        pop       = has_entry && sb.mem_ready;
    end

    // An array slot is pending when its distance from the head is below the occupancy.
    always_comb begin
        logic [PW-1:0] off;
        off    = '0;
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < cnt) && (addr_q[i] == sb.ld_addr))
                ld_hit = 1'b1;
        end
    end

    always_comb begin
        sb.stall    = (st_req && full) || (sb.ld_valid && ld_hit);
        sb.empty    = !has_entry;
        sb.count    = cnt;
        sb.mem_we   = has_entry ? we_q[rd_ptr]   : 4'b0000;
        sb.mem_addr = has_entry ? addr_q[rd_ptr] : 12'h000;
        sb.mem_din  = has_entry ? data_q[rd_ptr] : 32'h0000_0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is qualified by cnt, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= sb.st_addr;
            we_q[wr_ptr]   <= sb.st_we;
            data_q[wr_ptr] <= sb.st_data;
        end
    end
endmodule
